// File: rtl/support_mem_arbiter.sv
// Arbitrates the single-port synchronous support memory between the Z80-style
// support CPU and the SPI-fed DMA requester; CPU cycles are stretched with wait.
module support_mem_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 8,
   parameter int DMA_BURST = 2
) (
   input  logic              clk_i,
   input  logic              n_reset_i,
   input  logic [ADDR_W-1:0] cpu_a_i,
   input  logic [DATA_W-1:0] cpu_d_i,
   output logic [DATA_W-1:0] cpu_d_o,
   input  logic              cpu_nmreq_i,
   input  logic              cpu_nrd_i,
   input  logic              cpu_nwr_i,
   output logic              cpu_wait_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_a_i,
   input  logic [DATA_W-1:0] dma_d_i,
   output logic [DATA_W-1:0] dma_d_o,
   output logic              dma_ack_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic [DATA_W-1:0] mem_d_o,
   output logic              mem_we_o,
   input  logic [DATA_W-1:0] mem_d_i
);

   localparam int RUN_W = $clog2(DMA_BURST + 1);
   localparam logic [RUN_W-1:0] BURST_C = RUN_W'(DMA_BURST);

   typedef enum logic [2:0] {
      IDLE, CPU_ACC, CPU_RD, CPU_HOLD, DMA_ACC, DMA_RD
   } state_e;

   state_e            state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [DATA_W-1:0] mem_d_q, mem_d_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] cpu_d_q, cpu_d_d;
   logic [DATA_W-1:0] dma_d_q, dma_d_d;
   logic              ack_q, ack_d;
   logic              cpu_req;

   // Refresh cycles (mreq with both strobes high) never touch memory.
   assign cpu_req = ~cpu_nmreq_i & (~cpu_nrd_i | ~cpu_nwr_i);

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      mem_a_d  = mem_a_q;
      mem_d_d  = mem_d_q;
      mem_we_d = 1'b0;
      cpu_d_d  = cpu_d_q;
      dma_d_d  = dma_d_q;
      ack_d    = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie DMA keeps winning until it has used its burst allowance.
            if (cpu_req && (!dma_req_i || run_q >= BURST_C)) begin
               state_d  = CPU_ACC;
               mem_a_d  = cpu_a_i;
               mem_d_d  = cpu_d_i;
               mem_we_d = ~cpu_nwr_i;
               run_d    = '0;
            end else if (dma_req_i) begin
               state_d  = DMA_ACC;
               mem_a_d  = dma_a_i;
               mem_d_d  = dma_d_i;
               mem_we_d = dma_we_i;
               run_d    = (run_q >= BURST_C) ? BURST_C : run_q + RUN_W'(1);
            end
         end
         CPU_ACC: state_d = CPU_RD;
         CPU_RD: begin
            state_d = CPU_HOLD;
            cpu_d_d = mem_d_i;
         end
         CPU_HOLD: if (!cpu_req) state_d = IDLE;
         DMA_ACC: state_d = DMA_RD;
         DMA_RD: begin
            state_d = IDLE;
            dma_d_d = mem_d_i;
            ack_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge n_reset_i) begin
      if (!n_reset_i) begin
         state_q  <= IDLE;
         run_q    <= BURST_C;
         mem_a_q  <= '0;
         mem_d_q  <= '0;
         mem_we_q <= 1'b0;
         cpu_d_q  <= '0;
         dma_d_q  <= '0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         mem_a_q  <= mem_a_d;
         mem_d_q  <= mem_d_d;
         mem_we_q <= mem_we_d;
         cpu_d_q  <= cpu_d_d;
         dma_d_q  <= dma_d_d;
         ack_q    <= ack_d;
      end
   end

   // The CPU is released only once its read data is already on cpu_d_o.
   assign cpu_wait_o = cpu_req & (state_q != CPU_HOLD) & n_reset_i;
   assign cpu_d_o    = cpu_d_q;
   assign dma_d_o    = dma_d_q;
   assign dma_ack_o  = ack_q;
   assign mem_a_o    = mem_a_q;
   assign mem_d_o    = mem_d_q;
   assign mem_we_o   = mem_we_q;

endmodule
